// File: rtl/mersenne_reduce.sv
// rtl/mersenne_reduce.sv - Mersenne modular reduction by end-around folding, with optional subtract-two
module mersenne_reduce #(
    parameter int BITWIDTH = 32,
    parameter int PW       = 6
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*BITWIDTH-1:0] in_data,
    input  logic [PW-1:0]         p,
    input  logic                  sub_two,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITWIDTH-1:0]   out_data,
    output logic                  out_err
);

    localparam int AW = 2 * BITWIDTH;

    // ERR is a one-cycle stand-in for FOLD/FIX so an illegal exponent still
    // reports one edge after acceptance.
    typedef enum logic [2:0] {
        IDLE,
        FOLD,
        FIX,
        ERR,
        OUT
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         v_q;
    logic [AW-1:0]         m_q;
    logic [PW-1:0]         p_q;
    logic                  sub_two_q;
    logic                  out_valid_q;
    logic [BITWIDTH-1:0]   out_data_q;
    logic                  out_err_q;

    logic                  p_legal_d;
    logic [AW-1:0]         m_in_d;
    logic [AW-1:0]         fold_d;
    logic                  need_fold_d;
    logic [BITWIDTH-1:0]   m_lo_d;
    logic [BITWIDTH-1:0]   canon_d;
    logic [BITWIDTH-1:0]   fix_d;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    // Datapath: exponent check, modulus, one fold step and the final canonicalise/subtract.
    // Once v <= M (FIX), v and M both fit in BITWIDTH bits, so the fix-up runs narrow;
    // canon < 2 with M >= 3 keeps canon + M - 2 below M.
    always_comb begin
        p_legal_d   = (p >= PW'(2)) && (p <= PW'(BITWIDTH));
        m_in_d      = (AW'(1) << p) - AW'(1);
        fold_d      = (v_q & m_q) + (v_q >> p_q);
        need_fold_d = (v_q > m_q);
        m_lo_d      = m_q[BITWIDTH-1:0];
        canon_d     = (v_q == m_q) ? '0 : v_q[BITWIDTH-1:0];
        fix_d       = canon_d;
        if (sub_two_q) begin
            if (canon_d >= BITWIDTH'(2)) begin
                fix_d = canon_d - BITWIDTH'(2);
            end else begin
                fix_d = canon_d + m_lo_d - BITWIDTH'(2);
            end
        end
    end

    // Control FSM with registered result outputs; reset abandons any operation in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            v_q         <= '0;
            m_q         <= '0;
            p_q         <= '0;
            sub_two_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        v_q       <= in_data;
                        m_q       <= m_in_d;
                        p_q       <= p;
                        sub_two_q <= sub_two;
                        state_q   <= p_legal_d ? FOLD : ERR;
                    end
                end
                FOLD: begin
                    if (need_fold_d) begin
                        v_q <= fold_d;
                    end else begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    out_data_q  <= fix_d;
                    out_err_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                ERR: begin
                    out_data_q  <= '0;
                    out_err_q   <= 1'b1;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mersenne_reduce.sv
// tb/tb_mersenne_reduce.sv - self-checking bench for mersenne_reduce
module tb_mersenne_reduce;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [63:0] in_data   = '0;
    logic [5:0]  p         = '0;
    logic        sub_two   = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic        hold_prev = 1'b0;
    logic [31:0] d_prev    = '0;
    logic        e_prev    = 1'b0;

    mersenne_reduce #(.BITWIDTH(32), .PW(6)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .p         (p),
        .sub_two   (sub_two),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [63:0] y, input int pp, input bit s2);
        exp_t        r;
        logic [63:0] m;
        logic [63:0] v;
        if (pp < 2 || pp > 32) begin
            r.d = '0;
            r.e = 1'b1;
            return r;
        end
        m = (64'd1 << pp) - 64'd1;
        v = y % m;
        if (s2) v = (v >= 64'd2) ? v - 64'd2 : v + m - 64'd2;
        r.d = v[31:0];
        r.e = 1'b0;
        return r;
    endfunction

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, d_prev);
                chk("hold_err", out_err, e_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL stale_result: got out_valid=1 data=0x%0h, required no result", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result_data", out_data, mon_e.d);
                    chk("result_err", out_err, mon_e.e);
                end
            end
            hold_prev = out_valid && !out_ready;
            d_prev    = out_data;
            e_prev    = out_err;
        end
    end

    task automatic run_op(input logic [63:0] y, input int pp, input bit s2, input int exp_lat,
                          input bit chk_lit, input logic [31:0] lit, input int hold);
        int          n;
        int          lat;
        exp_t        e;
        logic [31:0] first;
        n = 0;
        @(posedge sys_clk); #1;
        while (!in_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        e = model(y, pp, s2);
        if (chk_lit) chk("model_literal", e.d, lit);
        exp_q.push_back(e);
        in_data  = y;
        p        = 6'(pp);
        sub_two  = s2;
        in_valid = 1'b1;
        if (hold > 0) out_ready = 1'b0;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        p        = 6'd1;
        in_data  = {$urandom, $urandom};
        sub_two  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        chk("out_valid_timeout", out_valid, 1);
        chk("in_ready_busy", in_ready, 0);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        if (chk_lit) chk("literal_out", out_data, lit);
        if (hold > 0) begin
            first = out_data;
            for (int i = 0; i < hold; i++) begin
                @(posedge sys_clk); #1;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_valid", out_valid, 1);
                chk("bp_data", out_data, first);
            end
            out_ready = 1'b1;
        end
        @(posedge sys_clk); #1;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        // Lucas-Lehmer chain for p=7
        run_op(64'd16,    7, 1, 2, 1, 32'd14, 0);
        run_op(64'd196,   7, 1, -1, 1, 32'd67, 0);
        run_op(64'd4489,  7, 1, -1, 1, 32'd42, 0);
        run_op(64'd1764,  7, 1, -1, 1, 32'd111, 0);
        run_op(64'd12321, 7, 1, -1, 1, 32'd0, 0);

        // Residue equal to M and just below it
        run_op(64'd127, 7, 0, 2, 1, 32'd0, 0);
        run_op(64'd126, 7, 0, 2, 1, 32'd126, 0);

        // Subtract-two wrap-around
        run_op(64'd1,   7, 1, -1, 1, 32'd126, 0);
        run_op(64'd0,   7, 1, -1, 1, 32'd125, 0);
        run_op(64'd127, 7, 1, -1, 1, 32'd125, 0);

        // Full width
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32, 0, 4, 1, 32'd0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32, 1, 4, 1, 32'hFFFF_FFFD, 0);

        // Backpressure
        run_op(64'd12345678, 13, 0, -1, 1, 32'd1841, 10);

        // Reset in the middle of a long fold sequence
        n = 0;
        @(posedge sys_clk); #1;
        while (!in_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        p        = 6'd2;
        sub_two  = 1'b0;
        in_valid = 1'b1;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("fold_busy", in_ready, 0);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_err", out_err, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (80) @(posedge sys_clk);
        #1;
        chk("post_rst_idle", in_ready, 1);

        // Illegal exponents, then a legal one
        run_op(64'd5,  1, 0, 1, 1, 32'd0, 0);
        run_op(64'd5, 33, 1, 1, 1, 32'd0, 0);
        run_op(64'd200, 7, 0, -1, 1, 32'd73, 0);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
